wb_stage: RTL and testbench

// Write-back stage of the vector pipeline, directly downstream of MEM_Stage. Registers
// the MEM results (load data and ALU/sum mux result) in a MEM/WB pipeline register,

---
 rtl/wb_stage.sv | 96 +++++++++
 tb/tb_wb_stage.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB pipeline register, write-back select, register-file
// write port, forwarding taps and a retired-instruction counter.
module wb_stage #(
  parameter int DATA_W = 192,
  parameter int REG_W  = 4,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic              stall,
  input  logic              flush,
  input  logic [3:0]        mem,
  input  logic              wb_en_in,
  input  logic [REG_W-1:0]  rd_in,
  input  logic [DATA_W-1:0] data_out,
  input  logic [DATA_W-1:0] mux_out,
  output logic              wb_valid,
  output logic              wb_we,
  output logic [REG_W-1:0]  wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              fwd_valid,
  output logic [REG_W-1:0]  fwd_rd,
  output logic [DATA_W-1:0] fwd_data,
  output logic [CNT_W-1:0]  retired
);

  localparam logic [3:0] MEM_LOAD  = 4'b1000;
  localparam logic [3:0] MEM_STORE = 4'b1001;

  // Loads write back memory data; everything else writes back the ALU/sum result.
  function automatic logic [DATA_W-1:0] wb_select(input logic [3:0]        m,
                                                  input logic [DATA_W-1:0] ld,
                                                  input logic [DATA_W-1:0] alu);
    return (m == MEM_LOAD) ? ld : alu;
  endfunction

  logic              vld_p0;
  logic              we_p0;
  logic [REG_W-1:0]  rd_p0;
  logic [DATA_W-1:0] data_p0;

  logic              vld_p1;
  logic              we_p1;
  logic [REG_W-1:0]  rd_p1;
  logic [DATA_W-1:0] data_p1;
  logic [CNT_W-1:0]  cnt_p1;

  logic              capture;

  // Stage p0: decode MEM control and form the candidate write-back entry
  always_comb begin
    vld_p0  = valid_in;
    we_p0   = valid_in & wb_en_in & (mem != MEM_STORE);
    rd_p0   = rd_in;
    data_p0 = wb_select(mem, data_out, mux_out);
    capture = ~flush & ~stall;
  end

  // Stage p1: MEM/WB register, priority rst > flush > stall > capture
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      we_p1   <= 1'b0;
      rd_p1   <= '0;
      data_p1 <= '0;
    end else if (flush) begin
      vld_p1  <= 1'b0;
      we_p1   <= 1'b0;
    end else if (!stall) begin
      vld_p1  <= vld_p0;
      we_p1   <= we_p0;
      rd_p1   <= rd_p0;
      data_p1 <= data_p0;
    end
  end

  // Retired counter: one per valid instruction captured, wrapping silently
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_p1 <= '0;
    end else if (capture && vld_p0) begin
      cnt_p1 <= cnt_p1 + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign wb_valid  = vld_p1;
  assign wb_we     = we_p1;
  assign wb_rd     = rd_p1;
  assign wb_data   = data_p1;
  assign fwd_valid = we_p1;
  assign fwd_rd    = rd_p1;
  assign fwd_data  = data_p1;
  assign retired   = cnt_p1;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: behavioural model checked every cycle plus directed
// literal expectations for reset, load, ALU/store, stall, flush and wrap.
module tb_wb_stage;

  localparam int DATA_W = 192;
  localparam int REG_W  = 4;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst, valid_in, stall, flush, wb_en_in;
  logic [3:0]        mem;
  logic [REG_W-1:0]  rd_in;
  logic [DATA_W-1:0] data_out, mux_out;
  logic              wb_valid, wb_we, fwd_valid;
  logic [REG_W-1:0]  wb_rd, fwd_rd;
  logic [DATA_W-1:0] wb_data, fwd_data;
  logic [CNT_W-1:0]  retired;

  int n_checks = 0;
  int n_err    = 0;

  localparam logic [DATA_W-1:0] PAT_A5 = {24{8'hA5}};
  localparam logic [DATA_W-1:0] PAT_5A = {24{8'h5A}};
  localparam logic [DATA_W-1:0] PAT_X  = {6{32'hDEADBEEF}};
  localparam logic [DATA_W-1:0] PAT_Y  = {6{32'h01234567}};

  wb_stage #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .stall(stall), .flush(flush),
    .mem(mem), .wb_en_in(wb_en_in), .rd_in(rd_in), .data_out(data_out),
    .mux_out(mux_out), .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd),
    .wb_data(wb_data), .fwd_valid(fwd_valid), .fwd_rd(fwd_rd),
    .fwd_data(fwd_data), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural model: what the stage must hold after each edge
  bit              m_ok = 0;
  bit              m_vld, m_we;
  int              m_rd, m_ret;
  logic [DATA_W-1:0] m_data;

  always @(posedge clk) begin
    if (rst) begin
      m_ok = 1; m_vld = 0; m_we = 0; m_rd = 0; m_data = '0; m_ret = 0;
    end else if (flush) begin
      m_vld = 0; m_we = 0;
    end else if (!stall) begin
      m_vld  = valid_in;
      m_we   = valid_in && wb_en_in && (mem != 4'b1001);
      m_rd   = rd_in;
      m_data = (mem == 4'b1000) ? data_out : mux_out;
      if (valid_in) m_ret = (m_ret + 1) % (1 << CNT_W);
    end
  end

  // Per-cycle compare against the model, away from the active edge
  always @(negedge clk) begin
    if (m_ok) begin
      check("m_valid",   DATA_W'(wb_valid),  DATA_W'(m_vld));
      check("m_we",      DATA_W'(wb_we),     DATA_W'(m_we));
      check("m_rd",      DATA_W'(wb_rd),     DATA_W'(m_rd));
      check("m_data",    wb_data,            m_data);
      check("m_fwd_vld", DATA_W'(fwd_valid), DATA_W'(m_we));
      check("m_fwd_rd",  DATA_W'(fwd_rd),    DATA_W'(m_rd));
      check("m_fwd_dat", fwd_data,           m_data);
      check("m_retired", DATA_W'(retired),   DATA_W'(m_ret));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1; valid_in = 1; stall = 0; flush = 0; wb_en_in = 1;
    mem = 4'b1000; rd_in = 3; data_out = PAT_A5; mux_out = PAT_5A;

    // Reset held two cycles with a valid instruction present
    cyc(); cyc();
    check("rst_valid",   DATA_W'(wb_valid), '0);
    check("rst_we",      DATA_W'(wb_we),    '0);
    check("rst_rd",      DATA_W'(wb_rd),    '0);
    check("rst_data",    wb_data,           '0);
    check("rst_retired", DATA_W'(retired),  '0);

    // Load
    rst = 0;
    cyc();
    check("ld_we",      DATA_W'(wb_we),    DATA_W'(1));
    check("ld_rd",      DATA_W'(wb_rd),    DATA_W'(3));
    check("ld_data",    wb_data,           PAT_A5);
    check("ld_retired", DATA_W'(retired),  DATA_W'(1));

    // ALU op then store
    mem = 4'b0010; rd_in = 7; mux_out = DATA_W'(1);
    cyc();
    check("alu_we",   DATA_W'(wb_we), DATA_W'(1));
    check("alu_data", wb_data,        DATA_W'(1));
    mem = 4'b1001; rd_in = 9; mux_out = PAT_5A;
    cyc();
    check("st_valid",   DATA_W'(wb_valid), DATA_W'(1));
    check("st_we",      DATA_W'(wb_we),    '0);
    check("st_retired", DATA_W'(retired),  DATA_W'(3));

    // Stall holds the captured entry while inputs move
    mem = 4'b0000; rd_in = 5; mux_out = PAT_X;
    cyc();
    stall = 1; rd_in = 6; mux_out = PAT_Y;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("stl_rd",      DATA_W'(wb_rd),   DATA_W'(5));
      check("stl_data",    wb_data,          PAT_X);
      check("stl_retired", DATA_W'(retired), DATA_W'(4));
      rd_in = REG_W'(10 + i);
    end
    stall = 0; rd_in = 6;
    cyc();
    check("rel_rd",      DATA_W'(wb_rd),   DATA_W'(6));
    check("rel_data",    wb_data,          PAT_Y);
    check("rel_retired", DATA_W'(retired), DATA_W'(5));

    // Flush and stall together with a valid instruction offered
    flush = 1; stall = 1; rd_in = 0; mux_out = PAT_A5;
    cyc();
    check("fl_valid",   DATA_W'(wb_valid), '0);
    check("fl_we",      DATA_W'(wb_we),    '0);
    check("fl_rd",      DATA_W'(wb_rd),    DATA_W'(6));
    check("fl_retired", DATA_W'(retired),  DATA_W'(5));
    flush = 0; stall = 0;

    // Bubble
    valid_in = 0;
    cyc();
    check("bub_valid",   DATA_W'(wb_valid), '0);
    check("bub_retired", DATA_W'(retired),  DATA_W'(5));

    // Counter wrap: 17 back-to-back valid instructions from zero
    rst = 1; valid_in = 1;
    cyc();
    rst = 0;
    for (int i = 1; i <= 17; i++) begin
      rd_in = REG_W'(i); mux_out = DATA_W'(i);
      cyc();
      if (i == 15) check("wrap_15", DATA_W'(retired), DATA_W'(15));
      if (i == 16) check("wrap_0",  DATA_W'(retired), '0);
      if (i == 17) check("wrap_1",  DATA_W'(retired), DATA_W'(1));
    end
    valid_in = 0;
    cyc(); cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
